// File: rtl/alu_arbiter.sv
// Two-port front end for one shared combinational ALU: arbitrates, registers the operands,
// drives the ALU for one cycle and hands a registered result back to the winning requester.
module alu_arbiter #(
  parameter int XLEN      = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_sel,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp0_zero,
  output logic            resp0_err,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_sel,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_result,
  output logic            resp1_zero,
  output logic            resp1_err,

  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0100;
  localparam logic [3:0] SEL_SLT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic            last_grant;
  logic            grant_any;
  logic            grant_id;
  logic            req_fire;
  logic            resp_fire;

  logic [XLEN-1:0] cap_a;
  logic [XLEN-1:0] cap_b;
  logic [3:0]      cap_sel;
  logic            cap_id;
  logic            cap_illegal;

  logic [XLEN-1:0] res_result;
  logic            res_zero;
  logic            res_err;

  function automatic logic sel_legal(input logic [3:0] s);
    return (s == SEL_AND) || (s == SEL_OR) || (s == SEL_ADD) ||
           (s == SEL_SUB) || (s == SEL_SLT);
  endfunction

  // Tie-break: round-robin favours whoever was not served last; fixed mode always favours req0.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_id  = (PRIO_MODE != 0) ? 1'b0 : ~last_grant;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
  end

  assign req_fire  = (state == IDLE) && grant_any && !rst;
  assign resp_fire = (state == RESP) && (cap_id ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_fire)  next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The ALU only ever sees captured operands during a legal EXEC; otherwise it idles on a harmless ADD.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = SEL_ADD;
    if (!rst) begin
      case (state)
        IDLE: begin
          req0_ready = grant_any && (grant_id == 1'b0);
          req1_ready = grant_any && (grant_id == 1'b1);
        end
        EXEC: begin
          if (!cap_illegal) begin
            alu_a   = cap_a;
            alu_b   = cap_b;
            alu_sel = cap_sel;
          end
        end
        RESP: begin
          resp0_valid = (cap_id == 1'b0);
          resp1_valid = (cap_id == 1'b1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_sel     <= SEL_ADD;
      cap_id      <= 1'b0;
      cap_illegal <= 1'b0;
    end else if (req_fire) begin
      last_grant  <= grant_id;
      cap_id      <= grant_id;
      cap_a       <= grant_id ? req1_a   : req0_a;
      cap_b       <= grant_id ? req1_b   : req0_b;
      cap_sel     <= grant_id ? req1_sel : req0_sel;
      cap_illegal <= !sel_legal(grant_id ? req1_sel : req0_sel);
    end
  end

  // Response registers load only at the end of EXEC, so they hold steady through any RESP stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_result <= '0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
    end else if (state == EXEC) begin
      if (cap_illegal) begin
        res_result <= '0;
        res_zero   <= 1'b0;
        res_err    <= 1'b1;
      end else begin
        res_result <= alu_result;
        res_zero   <= alu_zero;
        res_err    <= 1'b0;
      end
    end
  end

  assign resp0_result = res_result;
  assign resp0_zero   = res_zero;
  assign resp0_err    = res_err;
  assign resp1_result = res_result;
  assign resp1_zero   = res_zero;
  assign resp1_err    = res_err;

endmodule
